instr_fetch_responder: RTL
==========================

// Module: instr_fetch_responder
// PURPOSE
//  Responder side of the instruction-fetch interface. Accepts word-aligned PC requests from the
//  fetch stage and returns one 32-bit instruction per request. Backed by a 1-entry line buffer
//  (last-fetched word), with misses served over a req/ack instruction-memory bus. Sits between
//  the fetch stage and instruction memory. fetch_busy feeds the fetch stage's freeze input.
// PARAMETERS
//  NOP_INSTR  32'h0000_0013  instruction driven on instr when no valid instruction or on error
//  TIMEOUT    16             max cycles in BUSY/DRAIN before bus timeout; range 2..255
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  pc           in   32  fetch address, sampled when fetch_req=1
//  fetch_req    in   1   fetch stage presents pc this cycle
//  flush        in   1   branch/IRQ redirect: cancel current and in-flight fetch
//  invalidate   in   1   clear line buffer (fence.i)
//  instr        out  32  returned instruction, meaningful when instr_valid=1
//  instr_valid  out  1   one-cycle pulse per completed request
//  fetch_err    out  1   qualifies instr_valid: misaligned, mem_err or timeout
//  fetch_busy   out  1   combinational, state!=IDLE; fetch stage must freeze
//  mem_req      out  1   memory read request, registered
//  mem_addr     out  32  memory word address, registered, stable while mem_req=1
//  mem_ack      in   1   memory data valid, one cycle
//  mem_rdata    in   32  memory read data, valid with mem_ack
//  mem_err      in   1   memory error, valid with mem_ack
// BEHAVIOUR
//  Reset: state=IDLE; instr=NOP_INSTR; instr_valid, fetch_err, mem_req=0; mem_addr=0;
//   buf_valid=0; buf_tag=0; timeout counter=0. Reset mid-transaction abandons the access with no drain.
//  States: IDLE, BUSY (miss outstanding), DRAIN (flushed miss, awaiting ack to discard).
//  IDLE priority, in this order: flush (request dropped), then fetch_req.
//   pc[1:0]!=0: next cycle instr_valid=1, fetch_err=1, instr=NOP_INSTR. No bus access.
//   hit (buf_valid && buf_tag==pc[31:2]): next cycle instr_valid=1, instr=buf_data. Latency 1.
//   miss: mem_addr<={pc[31:2],2'b00}, mem_req<=1, go BUSY, counter cleared.
//  BUSY: mem_req and mem_addr held until mem_ack. Counter increments each cycle.
//   mem_ack && !flush && !mem_err: next cycle instr_valid=1, instr=mem_rdata;
//    buffer <= {tag, data}; buf_valid=1; mem_req<=0; go IDLE.
//   mem_ack && mem_err: instr_valid=1, fetch_err=1, instr=NOP_INSTR; buf_valid=0; go IDLE.
//   mem_ack && flush (same cycle): data discarded, no valid, buffer unchanged; go IDLE.
//   flush && !mem_ack: go DRAIN. mem_req stays high; requests are never retracted.
//   counter==TIMEOUT-1 && !mem_ack: mem_req<=0, buf_valid=0. If not flushed, instr_valid=1,
//    fetch_err=1, instr=NOP_INSTR. Go IDLE.
//  DRAIN: on mem_ack or timeout, mem_req<=0 and go IDLE. No instr_valid, no error, buffer unchanged.
//   Further flush is ignored.
//  fetch_req while state!=IDLE: ignored. The protocol requires fetch to freeze on fetch_busy.
//  invalidate: buf_valid<=0 in any state. Takes priority over a same-cycle buffer fill.
//   A same-cycle IDLE lookup treats the buffer as invalid (miss).
//  instr_valid and fetch_err are single-cycle pulses. instr holds its last value otherwise.
//  Tag compare uses pc[31:2] only. Counter is 8 bits and saturates.
// TESTING
//  T1 reset, fetch_req pc=0x100, mem_ack 3 cycles after mem_req, rdata=0x00500093
//     -> mem_addr=0x100; instr_valid 1 cycle after ack with instr=0x00500093; fetch_busy low after.
//  T2 repeat pc=0x100 -> no mem_req; instr_valid next cycle with 0x00500093.
//     Assert invalidate, then repeat -> mem_req issued again.
//  T3 miss pc=0x200, flush 1 cycle after mem_req, ack 2 cycles later
//     -> state DRAIN; mem_req held until ack; no instr_valid; buf still holds 0x100.
//  T4 pc=0x102 -> 1 cycle later instr_valid=1, fetch_err=1, instr=0x00000013; mem_req never rises.
//  T5 miss pc=0x300, never ack, TIMEOUT=16 -> mem_req drops after 16 cycles in BUSY;
//     fetch_err+instr_valid pulse; a following fetch of 0x100 misses.
//  T6 miss pc=0x400 with mem_ack+mem_err -> error pulse, buf_valid=0.
//     Also: rst asserted during BUSY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: 1-entry line buffer in front of a req/ack
// instruction-memory bus, with flush drain, bus timeout and error reporting.
module instr_fetch_responder #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  input  logic        flush,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        fetch_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [29:0] buf_tag_q, buf_tag_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        hit;
  logic        timeout;
  logic [7:0]  cnt_inc;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fetch_err_d   = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
    cnt_d         = cnt_q;

    // a same-cycle invalidate makes the lookup miss
    hit     = buf_valid_q && !invalidate && (buf_tag_q == pc[31:2]);
    timeout = (cnt_q == TO_LAST);
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (fetch_req) begin
          if (pc[1:0] != 2'b00) begin
            instr_valid_d = 1'b1;
            fetch_err_d   = 1'b1;
            instr_d       = NOP_INSTR;
          end else if (hit) begin
            instr_valid_d = 1'b1;
            instr_d       = buf_data_q;
          end else begin
            mem_addr_d = {pc[31:2], 2'b00};
            mem_req_d  = 1'b1;
            cnt_d      = 8'd0;
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (flush) begin
            state_d = IDLE;
          end else if (mem_err) begin
            instr_valid_d = 1'b1;
            fetch_err_d   = 1'b1;
            instr_d       = NOP_INSTR;
            buf_valid_d   = 1'b0;
          end else begin
            instr_valid_d = 1'b1;
            instr_d       = mem_rdata;
            buf_valid_d   = 1'b1;
            buf_tag_d     = mem_addr_q[31:2];
            buf_data_d    = mem_rdata;
          end
        end else if (timeout) begin
          mem_req_d   = 1'b0;
          buf_valid_d = 1'b0;
          state_d     = IDLE;
          if (!flush) begin
            instr_valid_d = 1'b1;
            fetch_err_d   = 1'b1;
            instr_d       = NOP_INSTR;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (mem_ack || timeout) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (invalidate) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'd0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= 30'd0;
      buf_data_q    <= 32'd0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      cnt_q         <= cnt_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_busy  = (state_q != IDLE);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule
